// File: rtl/control_unit.sv
// control_unit
//   Multicycle control FSM for the 8-bit datapath.
//   It sequences FETCH -> DECODE -> EXEC/MEM/BRANCH -> WB -> FETCH.
//   It drives the ALU operation select and the memory, IR, PC and register-file
//   strobes, and it counts retired instructions.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   opcode[2:0]     IR[7:5]; must stay stable from DECODE through retire
//   mem_ready       memory completes the current read/write this cycle
//   zero, eq        ALU result==0, ALU operands A==B
//   ALUOp[2:0]      000 add, 001 sub, 010 and, 011 or, 100 pass A
//   mem_read/mem_write, ir_load, pc_inc, pc_load, reg_write, wb_sel
//                   datapath strobes (combinational from state/opcode)
//   flag_z          registered zero flag, written when an ALU op leaves WB
//   halted          core stopped
//   instr_count     retired-instruction counter, wraps modulo 2^COUNT_W
//   state[2:0]      FSM state, for debug
module control_unit #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         opcode,
  input  logic               mem_ready,
  input  logic               zero,
  input  logic               eq,
  output logic [2:0]         ALUOp,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               pc_load,
  output logic               reg_write,
  output logic               wb_sel,
  output logic               flag_z,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_BEQ   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  state_t             r_state;
  logic               r_flag_z;
  logic [COUNT_W-1:0] r_count;

  // Opcodes 000-011 are the register-register ALU ops.
  logic w_alu_op;
  assign w_alu_op = ~opcode[2];

  // State, flag and retire counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_flag_z <= 1'b0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          if (w_alu_op)                                     r_state <= S_EXEC;
          else if (opcode == OP_LOAD || opcode == OP_STORE) r_state <= S_MEM;
          else if (opcode == OP_BEQ)                        r_state <= S_BRANCH;
          else                                              r_state <= S_HALT;
        end
        S_EXEC:   r_state <= S_WB;
        S_MEM: begin
          if (mem_ready) begin
            if (opcode == OP_STORE) begin
              r_state <= S_FETCH;
              r_count <= r_count + COUNT_W'(1);
            end else begin
              r_state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (w_alu_op) r_flag_z <= zero;
          r_count <= r_count + COUNT_W'(1);
          r_state <= S_FETCH;
        end
        S_BRANCH: begin
          r_count <= r_count + COUNT_W'(1);
          r_state <= S_FETCH;
        end
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_FETCH; // encoding 7 recovers to FETCH
      endcase
    end
  end

  // Control strobes: Moore from state/opcode, except that the FETCH handshake
  // and pc_load also follow mem_ready and eq. Everything is held low in reset.
  always_comb begin
    ALUOp     = 3'b000;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 1'b0;
    halted    = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_load  = mem_ready;
          pc_inc   = mem_ready;
        end
        S_EXEC: ALUOp = opcode;
        S_MEM: begin
          ALUOp     = 3'b100;
          mem_read  = (opcode == OP_LOAD);
          mem_write = (opcode == OP_STORE);
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_sel    = (opcode == OP_LOAD);
          if (w_alu_op) ALUOp = opcode;
        end
        S_BRANCH: begin
          ALUOp   = 3'b001;
          pc_load = eq;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign flag_z      = r_flag_z;
  assign instr_count = r_count;
  assign state       = r_state;

  // OP_HALT is the fall-through decode case; named here for readability.
  logic w_unused_halt_op;
  assign w_unused_halt_op = (opcode == OP_HALT);

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle control FSM for the 8-bit datapath. It sequences fetch, decode, execute, memory and writeback, drives the 3-bit ALU operation select, and consumes the ALU `zero` and `eq` flags. It sits between the instruction register and memory handshake on one side and the ALU, register file and PC on the other.

## Interface
- `COUNT_W`, default 16: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `opcode`  in  3  `IR[7:5]` from the datapath instruction register
- `mem_ready`  in  1  memory completes the current read or write this cycle
- `zero`  in  1  ALU result == 0
- `eq`  in  1  ALU operands A == B
- `ALUOp`  out  3  ALU operation select: 000 add, 001 sub, 010 and, 011 or, 100 pass A
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `ir_load`  out  1  load IR from memory data
- `pc_inc`  out  1  PC <= PC + 1
- `pc_load`  out  1  PC <= branch target
- `reg_write`  out  1  register file write enable
- `wb_sel`  out  1  writeback source: 0 ALU result, 1 memory data
- `flag_z`  out  1  registered zero flag
- `halted`  out  1  core stopped
- `instr_count`  out  COUNT_W  retired-instruction counter
- `state`  out  3  FSM state, for debug

## Operation
Opcodes:
- 000 ADD, 001 SUB, 010 AND, 011 OR
- 100 LOAD, 101 STORE
- 110 BEQ
- 111 HALT

States and encodings:
- FETCH = 0
  - Asserts `mem_read`.
  - While `mem_ready` = 0: stays in FETCH; `ir_load` and `pc_inc` stay 0.
  - When `mem_ready` = 1: asserts `ir_load` and `pc_inc` in the same cycle, then goes to DECODE.
- DECODE = 1
  - No outputs asserted.
  - Next state by `opcode`: 000–011 go to EXEC; 100/101 go to MEM; 110 goes to BRANCH; 111 goes to HALT.
- EXEC = 2
  - `ALUOp` = `opcode`.
  - Goes to WB.
- MEM = 3
  - `ALUOp` = 100, passing the register operand as address/data.
  - LOAD asserts `mem_read`; STORE asserts `mem_write`.
  - Holds in MEM until `mem_ready`.
  - Then LOAD goes to WB; STORE goes to FETCH and retires.
- WB = 4
  - Asserts `reg_write`.
  - `wb_sel` = 1 for LOAD, 0 for ALU ops.
  - ALU ops only: `ALUOp` = `opcode` is held and `flag_z` <= `zero`.
  - Retires, then goes to FETCH.
- BRANCH = 5
  - `ALUOp` = 001.
  - `pc_load` = `eq`.
  - Retires, then goes to FETCH.
- HALT = 6
  - `halted` = 1; all other controls 0.
  - Remains in HALT until reset.

Output and counter rules:
- Outputs are Moore-style from `state` and `opcode`. Exceptions: `ir_load`, `pc_inc`, `pc_load` and the MEM exit also depend on `mem_ready` or `eq`.
- Outputs not listed for a state are 0, and `ALUOp` defaults to 000.
- Retire means `instr_count` <= `instr_count` + 1, modulo 2^COUNT_W (wraps to 0).
- State encoding 7 is illegal and goes to FETCH on the next edge.
- `opcode` must be stable from DECODE through retire; the block does not latch it.

## Timing
- Reset: while `rst_n` = 0 at a rising edge, the next state is FETCH, `flag_z` = 0, `instr_count` = 0 and `halted` = 0.
  - While `rst_n` is low, all combinational control outputs are forced to 0.
  - A reset mid-instruction abandons it with no retire and no register write.
- Latency with `mem_ready` held high:
  - ALU op: 4 cycles (F, D, E, W)
  - LOAD: 4 cycles (F, D, M, W)
  - STORE: 3 cycles
  - BEQ: 3 cycles
  - Each cycle `mem_ready` is low in FETCH or MEM adds one cycle.
- `mem_read`/`mem_write` hold steady until the cycle `mem_ready` is sampled high. A `mem_ready` pulse outside FETCH/MEM is ignored.
- `instr_count` updates on the edge leaving the retiring state.
- `flag_z` updates on the edge leaving WB.
- HALT is not retired.

## Test plan
- Reset, then `opcode` = 000 with `mem_ready` = 1 -> `state` goes 0,1,2,4,0; `ALUOp` = 000 in EXEC and WB; `reg_write` = 1 only in WB; `instr_count` = 1.
- SUB with `zero` = 1 in WB -> `flag_z` = 1. A following OR with `zero` = 0 -> `flag_z` = 0.
- LOAD with `mem_ready` low for 3 cycles in MEM -> `mem_read` high for 4 MEM cycles, then WB with `wb_sel` = 1. STORE -> `mem_write` in MEM, no `reg_write`, 3 cycles total.
- BEQ with `eq` = 1 -> `pc_load` = 1 for one cycle and `ALUOp` = 001. With `eq` = 0 -> `pc_load` = 0. `instr_count` increments in both cases.
- HALT -> `halted` = 1 and stays 1 across 10 cycles while `instr_count` is unchanged. Drive `rst_n` low for one edge mid-EXEC of an ADD -> `state` = 0, all outputs 0, `instr_count` = 0.
- Preload 2^16−1 retirements (or force the counter), retire one more -> `instr_count` = 0.
